// File: rtl/seq_pair_adder.sv
// Wide adder built from one 2-bit slice, two bits per clock, LSB first.
// Start/done handshake in front, held result registers behind.
module seq_pair_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NS = WIDTH / 2;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DNE  = 2'd2;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] br;
  logic [WIDTH-1:0] ws;
  logic [WIDTH-1:0] wnext;
  logic [1:0]       x;
  logic [1:0]       y;
  logic [2:0]       slice;
  logic             last;

  // The single shared 2-bit slice, steered by k.
  always_comb begin
    x     = ar[{k, 1'b0} +: 2];
    y     = br[{k, 1'b0} +: 2];
    slice = {1'b0, x} + {1'b0, y} + {2'b00, carry};
    wnext = ws;
    wnext[{k, 1'b0} +: 2] = slice[1:0];
    last  = (k == KLAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      carry <= 1'b0;
      ar    <= '0;
      br    <= '0;
      ws    <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          ws    <= wnext;
          carry <= slice[2];
          if (last) begin
            sum   <= wnext;
            cout  <= slice[2];
            ovf   <= (ar[WIDTH-1] == br[WIDTH-1]) &&
                     (wnext[WIDTH-1] != ar[WIDTH-1]);
            k     <= '0;
            state <= DNE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          if (start) begin
            ar    <= a;
            br    <= b;
            carry <= cin;
            k     <= '0;
            ws    <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DNE);

endmodule

// File: tb/tb_seq_pair_adder.sv
// Directed bench for seq_pair_adder, WIDTH=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_seq_pair_adder;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int npass;
  int ntot;
  int cyc;

  seq_pair_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Launch one add, check busy span, latency and result.
  task automatic run_op(input string tag,
                        input logic [7:0] ia,
                        input logic [7:0] ib,
                        input logic ic,
                        input logic [7:0] es,
                        input logic ec,
                        input logic eo);
    int t0;
    int nb;
    int n;
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk);
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    a = ~ia; b = ~ib; cin = ~ic;
    nb = 0;
    n = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busycyc"}, nb, 4);
    chk({tag, "_lat"}, cyc - t0, 4);
    chk({tag, "_busy_in_done"}, busy, 0);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n;
    int nd;
    logic [7:0] hs;
    logic hc;
    logic ho;
    npass = 0;
    ntot = 0;
    reset = 1'b0;
    start = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0;

    // Reset before any clock edge
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op("basic", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
    run_op("wrap1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("wrap2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Start held high through RUN, accepted again in DONE
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'hAA; b = 8'h55;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("busy_first_done", done, 1);
    chk("busy_first_sum", sum, 8'h30);
    chk("busy_first_cout", cout, 0);
    @(negedge clk);
    start = 1'b0;
    chk("busy_b2b_busy", busy, 1);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("busy_second_done", done, 1);
    chk("busy_gap", n, 5);
    chk("busy_second_sum", sum, 8'hFF);
    chk("busy_second_cout", cout, 0);
    @(negedge clk);

    // Reset in the second RUN cycle
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mrst_running", busy, 1);
    reset = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_sum", sum, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mrst_nodone", nd, 0);
    chk("mrst_idle", busy, 0);
    run_op("mrst_new", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    // Result hold while inputs toggle with start low
    hs = sum; hc = cout; ho = ovf;
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = ~cin;
      @(negedge clk);
      chk("hold_sum", sum, hs);
      chk("hold_flags", {cout, ovf}, {hc, ho});
      chk("hold_bd", {busy, done}, 2'b00);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
